// File: rtl/timer_in_cond.sv
// timer_in_cond: conditions a raw external clock/pulse line for d_ip_timer.
// The raw line is synchronised into clk, glitch-filtered, edge-selected and
// prescaled. The block produces a one-cycle count enable and a clean level.
// A small register window (CTRL, FILT, PRESC, STATUS) sits on the shared bus
// and is only selected while mod_en is high.
module timer_in_cond #(
  parameter int SYNC_STAGES = 2,
  parameter int EDGE_CNT_W  = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] addr,
  input  logic       wr_en,
  input  logic       mod_en,
  input  logic [7:0] wdata,
  output logic [7:0] rdata,
  input  logic       timer_in,
  output logic       filt_out,
  output logic       cnt_en,
  output logic       edge_ovf
);

  localparam logic [5:0] ADDR_CTRL   = 6'h00;
  localparam logic [5:0] ADDR_FILT   = 6'h01;
  localparam logic [5:0] ADDR_PRESC  = 6'h02;
  localparam logic [5:0] ADDR_STATUS = 6'h03;

  // ---------------------------------------------------------------------
  // Register file
  // ---------------------------------------------------------------------
  logic [2:0]            ctrl_reg;      // [2] EN, [1:0] EDGE_SEL
  logic [3:0]            filt_len_reg;  // filter length
  logic [7:0]            presc_reg;     // prescale terminal value
  logic [EDGE_CNT_W-1:0] edge_cnt_reg;  // wrapping qualified-edge counter
  logic [EDGE_CNT_W-1:0] edge_cnt_next;

  logic       en;
  logic [1:0] edge_sel;
  logic       bus_wr;
  logic       wr_ctrl;
  logic       wr_filt;
  logic       wr_presc;
  logic       wr_status;

  assign en       = ctrl_reg[2];
  assign edge_sel = ctrl_reg[1:0];

  // Write decode: one strobe per register, only while the block is selected.
  assign bus_wr    = mod_en & wr_en;
  assign wr_ctrl   = bus_wr && (addr == ADDR_CTRL);
  assign wr_filt   = bus_wr && (addr == ADDR_FILT);
  assign wr_presc  = bus_wr && (addr == ADDR_PRESC);
  assign wr_status = bus_wr && (addr == ADDR_STATUS);

  // Configuration registers; new values take effect from the next cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl_reg     <= 3'd0;
      filt_len_reg <= 4'd0;
      presc_reg    <= 8'd0;
    end else begin
      if (wr_ctrl)  ctrl_reg     <= wdata[2:0];
      if (wr_filt)  filt_len_reg <= wdata[3:0];
      if (wr_presc) presc_reg    <= wdata;
    end
  end

  // ---------------------------------------------------------------------
  // Synchroniser: a plain flop chain, always running regardless of EN.
  // ---------------------------------------------------------------------
  logic sync_reg [SYNC_STAGES];
  logic sync_q;

  // First stage samples the asynchronous pin.
  always_ff @(posedge clk) begin
    if (rst) sync_reg[0] <= 1'b0;
    else     sync_reg[0] <= timer_in;
  end

  genvar gi;
  generate
    for (gi = 1; gi < SYNC_STAGES; gi++) begin : g_sync
      // Each further stage re-registers the previous one.
      always_ff @(posedge clk) begin
        if (rst) sync_reg[gi] <= 1'b0;
        else     sync_reg[gi] <= sync_reg[gi-1];
      end
    end
  endgenerate

  assign sync_q = sync_reg[SYNC_STAGES-1];

  // ---------------------------------------------------------------------
  // Glitch filter: filt_out only moves after sync_q has disagreed with it
  // for filt_len+1 consecutive cycles. With EN low it just tracks sync_q,
  // which is what makes a later enable edge-free.
  // ---------------------------------------------------------------------
  logic       filt_out_reg;
  logic       filt_out_next;
  logic [3:0] filt_cnt_reg;
  logic [3:0] filt_cnt_next;

  // Next-state for the filter level and its disagreement counter.
  always_comb begin
    filt_out_next = filt_out_reg;
    filt_cnt_next = 4'd0;
    if (!en) begin
      filt_out_next = sync_q;
    end else if (sync_q != filt_out_reg) begin
      if (filt_cnt_reg == filt_len_reg) begin
        filt_out_next = ~filt_out_reg;
      end else begin
        filt_cnt_next = filt_cnt_reg + 4'd1;
      end
    end
    // Changing the filter length restarts any run in progress.
    if (wr_filt) filt_cnt_next = 4'd0;
  end

  // Filter state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      filt_out_reg <= 1'b0;
      filt_cnt_reg <= 4'd0;
    end else begin
      filt_out_reg <= filt_out_next;
      filt_cnt_reg <= filt_cnt_next;
    end
  end

  assign filt_out = filt_out_reg;

  // ---------------------------------------------------------------------
  // Edge qualification: compare filt_out against its previous value and
  // register a strobe when the direction matches EDGE_SEL.
  // ---------------------------------------------------------------------
  logic filt_prev_reg;
  logic filt_prev_next;
  logic qual_reg;
  logic qual_next;
  logic rise;
  logic fall;

  assign rise = filt_out_reg & ~filt_prev_reg;
  assign fall = ~filt_out_reg & filt_prev_reg;

  // While disabled the history is preloaded with the value filt_out is about
  // to take, so history and level already agree when EN comes back on.
  always_comb begin
    filt_prev_next = en ? filt_out_reg : sync_q;
    qual_next      = en & ((rise & edge_sel[0]) | (fall & edge_sel[1]));
  end

  // Edge history and qualified-edge strobe.
  always_ff @(posedge clk) begin
    if (rst) begin
      filt_prev_reg <= 1'b0;
      qual_reg      <= 1'b0;
    end else begin
      filt_prev_reg <= filt_prev_next;
      qual_reg      <= qual_next;
    end
  end

  // ---------------------------------------------------------------------
  // Prescaler: one cnt_en for every presc_reg+1 qualified edges.
  // ---------------------------------------------------------------------
  logic [7:0] presc_cnt_reg;
  logic [7:0] presc_cnt_next;
  logic       cnt_en_reg;
  logic       cnt_en_next;
  logic       qual_eff;

  // A strobe left over from before a disable must not count.
  assign qual_eff = qual_reg & en;

  // Next-state for the prescale counter and the count-enable pulse.
  always_comb begin
    presc_cnt_next = presc_cnt_reg;
    cnt_en_next    = 1'b0;
    if (!en) begin
      presc_cnt_next = 8'd0;
    end else if (qual_reg) begin
      if (presc_cnt_reg == presc_reg) begin
        cnt_en_next    = 1'b1;
        presc_cnt_next = 8'd0;
      end else begin
        presc_cnt_next = presc_cnt_reg + 8'd1;
      end
    end
    // A new prescale value restarts the division from zero.
    if (wr_presc) presc_cnt_next = 8'd0;
  end

  // Prescaler state and registered count enable.
  always_ff @(posedge clk) begin
    if (rst) begin
      presc_cnt_reg <= 8'd0;
      cnt_en_reg    <= 1'b0;
    end else begin
      presc_cnt_reg <= presc_cnt_next;
      cnt_en_reg    <= cnt_en_next;
    end
  end

  assign cnt_en = cnt_en_reg;

  // ---------------------------------------------------------------------
  // Edge counter: counts every qualified edge, wraps with a pulse on
  // edge_ovf. A STATUS write beats a simultaneous increment.
  // ---------------------------------------------------------------------
  logic edge_ovf_reg;
  logic edge_ovf_next;

  // Next-state for the edge counter and its wrap pulse.
  always_comb begin
    edge_cnt_next = edge_cnt_reg;
    edge_ovf_next = 1'b0;
    if (wr_status) begin
      edge_cnt_next = '0;
    end else if (qual_eff) begin
      edge_cnt_next = edge_cnt_reg + EDGE_CNT_W'(1);
      edge_ovf_next = &edge_cnt_reg;
    end
  end

  // Edge counter state and registered wrap pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      edge_cnt_reg <= '0;
      edge_ovf_reg <= 1'b0;
    end else begin
      edge_cnt_reg <= edge_cnt_next;
      edge_ovf_reg <= edge_ovf_next;
    end
  end

  assign edge_ovf = edge_ovf_reg;

  // ---------------------------------------------------------------------
  // Read path
  // ---------------------------------------------------------------------
  logic [7:0] status_rd;

  generate
    if (EDGE_CNT_W >= 8) begin : g_status_wide
      assign status_rd = edge_cnt_reg[7:0];
    end else begin : g_status_narrow
      assign status_rd = {{(8-EDGE_CNT_W){1'b0}}, edge_cnt_reg};
    end
  endgenerate

  // Combinational read mux; unselected block or unmapped address reads 0.
  always_comb begin
    rdata = 8'h00;
    if (mod_en) begin
      case (addr)
        ADDR_CTRL:   rdata = {5'd0, ctrl_reg};
        ADDR_FILT:   rdata = {4'd0, filt_len_reg};
        ADDR_PRESC:  rdata = presc_reg;
        ADDR_STATUS: rdata = status_rd;
        default:     rdata = 8'h00;
      endcase
    end
  end

endmodule

// File: tb/tb_timer_in_cond.sv
// Testbench for timer_in_cond: randomized input waveforms checked cycle by
// cycle against a run-length reference model of the conditioning chain.
module tb_timer_in_cond;

  localparam int S = 2;  // synchroniser depth used for the DUT

  logic       clk;
  logic       rst;
  logic [5:0] addr;
  logic       wr_en;
  logic       mod_en;
  logic [7:0] wdata;
  logic [7:0] rdata;
  logic       timer_in;
  logic       filt_out;
  logic       cnt_en;
  logic       edge_ovf;

  int checks   = 0;
  int failures = 0;

  timer_in_cond #(.SYNC_STAGES(S), .EDGE_CNT_W(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .addr     (addr),
    .wr_en    (wr_en),
    .mod_en   (mod_en),
    .wdata    (wdata),
    .rdata    (rdata),
    .timer_in (timer_in),
    .filt_out (filt_out),
    .cnt_en   (cnt_en),
    .edge_ovf (edge_ovf)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  // Waveform, observations and model expectations (index = clock edge).
  bit   stim[$];
  logic obs_filt[$], obs_cnt[$], obs_ovf[$];
  bit   exp_filt[$], exp_cnt[$], exp_ovf[$];
  int   cfg_en, cfg_filt, cfg_presc;
  logic [1:0] cfg_sel;
  int   model_edges;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_wr(input logic [5:0] a, input logic [7:0] d);
    addr = a; wdata = d; mod_en = 1'b1; wr_en = 1'b1;
    tick();
    wr_en = 1'b0; mod_en = 1'b0;
    $display("wr addr=%02h data=%02h", a, d);
  endtask

  task automatic bus_rd(input logic [5:0] a, output logic [7:0] d);
    addr = a; mod_en = 1'b1;
    #1;
    d = rdata;
    mod_en = 1'b0;
    $display("rd addr=%02h data=%02h", a, d);
  endtask

  task automatic do_reset();
    rst = 1'b1; timer_in = 1'b0; wr_en = 1'b0; mod_en = 1'b0;
    tick(); tick();
    rst = 1'b0;
  endtask

  // Level seen at sync_q just after edge k: the input sampled S-1 edges earlier.
  function automatic bit s_at(int k);
    int idx;
    idx = k - S + 1;
    if (idx < 0) return 1'b0;
    return stim[idx];
  endfunction

  // Reference model from the behavioural rules: the level flips once sync_q has
  // disagreed with it for FILT+1 consecutive cycles (or copies sync_q when
  // disabled); each matching flip is qualified edge n, which gives cnt_en two
  // edges later when n is a multiple of PRESC+1, and edge_ovf when n hits 256.
  task automatic build_model();
    int n;
    bit f_prev, f, all_diff;
    n = stim.size();
    exp_filt = {}; exp_cnt = {}; exp_ovf = {};
    for (int k = 0; k < n; k++) begin
      exp_cnt.push_back(1'b0);
      exp_ovf.push_back(1'b0);
    end
    model_edges = 0;
    f_prev = 1'b0;
    for (int k = 0; k < n; k++) begin
      if (cfg_en == 0) begin
        f = s_at(k - 1);
      end else begin
        all_diff = 1'b1;
        for (int j = 0; j <= cfg_filt; j++)
          if (s_at(k - 1 - j) == f_prev) all_diff = 1'b0;
        f = all_diff ? ~f_prev : f_prev;
      end
      exp_filt.push_back(f);
      if (cfg_en != 0 && f != f_prev && ((f && cfg_sel[0]) || (!f && cfg_sel[1]))) begin
        model_edges++;
        if (k + 2 < n) begin
          if (model_edges % (cfg_presc + 1) == 0) exp_cnt[k+2] = 1'b1;
          if (model_edges % 256 == 0) exp_ovf[k+2] = 1'b1;
        end
      end
      f_prev = f;
    end
  endtask

  // Drive the stimulus waveform one sample per edge and record the outputs.
  task automatic run_wave();
    obs_filt = {}; obs_cnt = {}; obs_ovf = {};
    foreach (stim[k]) begin
      timer_in = stim[k];
      tick();
      obs_filt.push_back(filt_out);
      obs_cnt.push_back(cnt_en);
      obs_ovf.push_back(edge_ovf);
    end
    build_model();
    $display("wave cycles=%0d model_edges=%0d", stim.size(), model_edges);
  endtask

  task automatic configure(input int en, input logic [1:0] sel, input int f, input int p);
    cfg_en = en; cfg_sel = sel; cfg_filt = f; cfg_presc = p;
    bus_wr(6'h01, 8'(f));
    bus_wr(6'h02, 8'(p));
    bus_wr(6'h00, {5'd0, en[0], sel});
  endtask

  // ---------------------------------------------------------------------
  task automatic test_reset();
    logic [7:0] d;
    rst = 1'b1; timer_in = 1'b1; wr_en = 1'b0; mod_en = 1'b0; addr = '0; wdata = '0;
    tick(); tick(); tick();
    checks++;
    if ({filt_out, cnt_en, edge_ovf} !== 3'b000) begin
      failures++;
      $display("FAIL reset_outputs got=%b required=000", {filt_out, cnt_en, edge_ovf});
    end
    for (int a = 0; a < 4; a++) begin
      bus_rd(6'(a), d);
      checks++;
      if (d !== 8'h00) begin
        failures++;
        $display("FAIL reset_reg%0d got=%02h required=00", a, d);
      end
    end
    rst = 1'b0; timer_in = 1'b0;
    repeat (6) tick();
    $display("test_reset done");
  endtask

  task automatic test_registers();
    logic [7:0] v0, v1, v2, d;
    logic [5:0] other;
    do_reset();
    v0 = 8'($urandom); v1 = 8'($urandom); v2 = 8'($urandom);
    other = 6'($urandom_range(4, 63));
    bus_wr(6'h00, v0); bus_wr(6'h01, v1); bus_wr(6'h02, v2);
    bus_wr(other, 8'hA5);
    bus_rd(6'h00, d); checks++;
    if (d !== {5'd0, v0[2:0]}) begin failures++; $display("FAIL reg_ctrl got=%02h required=%02h", d, {5'd0, v0[2:0]}); end
    bus_rd(6'h01, d); checks++;
    if (d !== {4'd0, v1[3:0]}) begin failures++; $display("FAIL reg_filt got=%02h required=%02h", d, {4'd0, v1[3:0]}); end
    bus_rd(6'h02, d); checks++;
    if (d !== v2) begin failures++; $display("FAIL reg_presc got=%02h required=%02h", d, v2); end
    bus_rd(other, d); checks++;
    if (d !== 8'h00) begin failures++; $display("FAIL reg_unmapped got=%02h required=00", d); end
    // Write strobe without block select must be ignored.
    addr = 6'h02; wdata = ~v2; wr_en = 1'b1; mod_en = 1'b0;
    tick();
    wr_en = 1'b0;
    #1; checks++;
    if (rdata !== 8'h00) begin failures++; $display("FAIL reg_unselected_read got=%02h required=00", rdata); end
    bus_rd(6'h02, d); checks++;
    if (d !== v2) begin failures++; $display("FAIL reg_unselected_write got=%02h required=%02h", d, v2); end
    $display("test_registers done");
  endtask

  task automatic test_clean_edges();
    int r, first_pulse, pulses;
    logic [7:0] d;
    do_reset();
    configure(1, 2'b01, 0, 0);
    stim = {};
    repeat ($urandom_range(3, 9)) stim.push_back(1'b0);
    r = stim.size();
    repeat (5) begin
      repeat (5) stim.push_back(1'b1);
      repeat (5) stim.push_back(1'b0);
    end
    repeat (24) stim.push_back(1'b0);
    run_wave();
    first_pulse = -1; pulses = 0;
    for (int k = 0; k < obs_cnt.size(); k++) begin
      checks++;
      if ({obs_filt[k], obs_cnt[k], obs_ovf[k]} !== {exp_filt[k], exp_cnt[k], exp_ovf[k]}) begin
        failures++;
        $display("FAIL clean_edges cycle=%0d got=%b required=%b", k,
                 {obs_filt[k], obs_cnt[k], obs_ovf[k]}, {exp_filt[k], exp_cnt[k], exp_ovf[k]});
      end
      if (obs_cnt[k] === 1'b1) begin
        pulses++;
        if (first_pulse < 0) first_pulse = k;
      end
    end
    checks++;
    if (first_pulse != r + 4) begin failures++; $display("FAIL clean_first_pulse got=%0d required=%0d", first_pulse, r + 4); end
    checks++;
    if (pulses != 5) begin failures++; $display("FAIL clean_pulse_count got=%0d required=5", pulses); end
    bus_rd(6'h03, d); checks++;
    if (d !== 8'h05) begin failures++; $display("FAIL clean_status got=%02h required=05", d); end
    $display("test_clean_edges done");
  endtask

  task automatic test_glitch();
    int first_rise;
    do_reset();
    configure(1, 2'b01, 3, 0);
    stim = {};
    repeat (4) stim.push_back(1'b0);
    repeat (3) stim.push_back(1'b1);
    repeat (10) stim.push_back(1'b0);
    repeat (5) stim.push_back(1'b1);   // starts at edge 17
    repeat (12) stim.push_back(1'b0);
    repeat (10) begin
      repeat ($urandom_range(1, 7)) stim.push_back(1'b1);
      repeat ($urandom_range(1, 8)) stim.push_back(1'b0);
    end
    repeat (24) stim.push_back(1'b0);
    run_wave();
    first_rise = -1;
    for (int k = 0; k < obs_filt.size(); k++) begin
      checks++;
      if ({obs_filt[k], obs_cnt[k], obs_ovf[k]} !== {exp_filt[k], exp_cnt[k], exp_ovf[k]}) begin
        failures++;
        $display("FAIL glitch cycle=%0d got=%b required=%b", k,
                 {obs_filt[k], obs_cnt[k], obs_ovf[k]}, {exp_filt[k], exp_cnt[k], exp_ovf[k]});
      end
      if (first_rise < 0 && obs_filt[k] === 1'b1) first_rise = k;
    end
    // 3-cycle pulse rejected; 5-cycle pulse lands on the 6th edge after edge 17.
    checks++;
    if (first_rise != 22) begin failures++; $display("FAIL glitch_first_rise got=%0d required=22", first_rise); end
    $display("test_glitch done");
  endtask

  task automatic test_prescale_both();
    int pulses, f;
    bit lvl;
    logic [7:0] d;
    do_reset();
    f = $urandom_range(0, 2);
    configure(1, 2'b11, f, 3);
    stim = {};
    lvl = 1'b0;
    repeat ($urandom_range(3, 6)) stim.push_back(lvl);
    repeat (16) begin
      lvl = ~lvl;
      repeat (f + 1 + $urandom_range(0, 4)) stim.push_back(lvl);
    end
    repeat (24) stim.push_back(lvl);
    run_wave();
    pulses = 0;
    for (int k = 0; k < obs_cnt.size(); k++) begin
      checks++;
      if ({obs_filt[k], obs_cnt[k], obs_ovf[k]} !== {exp_filt[k], exp_cnt[k], exp_ovf[k]}) begin
        failures++;
        $display("FAIL prescale cycle=%0d got=%b required=%b", k,
                 {obs_filt[k], obs_cnt[k], obs_ovf[k]}, {exp_filt[k], exp_cnt[k], exp_ovf[k]});
      end
      if (obs_cnt[k] === 1'b1) pulses++;
    end
    checks++;
    if (pulses != 4) begin failures++; $display("FAIL prescale_pulse_count got=%0d required=4", pulses); end
    bus_rd(6'h03, d); checks++;
    if (d !== 8'h10) begin failures++; $display("FAIL prescale_status got=%02h required=10", d); end
    $display("test_prescale_both done");
  endtask

  task automatic build_toggles(input int count);
    bit lvl;
    stim = {};
    lvl = 1'b0;
    repeat (3) stim.push_back(lvl);
    repeat (count) begin
      lvl = ~lvl;
      repeat ($urandom_range(1, 3)) stim.push_back(lvl);
    end
    repeat (24) stim.push_back(lvl);
  endtask

  task automatic test_wrap();
    int ovfs;
    logic [7:0] d;
    // Plain wrap on the 256th qualified edge.
    do_reset();
    configure(1, 2'b11, 0, 0);
    build_toggles(256);
    run_wave();
    ovfs = 0;
    for (int k = 0; k < obs_ovf.size(); k++) begin
      checks++;
      if ({obs_filt[k], obs_cnt[k], obs_ovf[k]} !== {exp_filt[k], exp_cnt[k], exp_ovf[k]}) begin
        failures++;
        $display("FAIL wrap cycle=%0d got=%b required=%b", k,
                 {obs_filt[k], obs_cnt[k], obs_ovf[k]}, {exp_filt[k], exp_cnt[k], exp_ovf[k]});
      end
      if (obs_ovf[k] === 1'b1) ovfs++;
    end
    checks++;
    if (ovfs != 1) begin failures++; $display("FAIL wrap_ovf_count got=%0d required=1", ovfs); end
    bus_rd(6'h03, d); checks++;
    if (d !== 8'h00) begin failures++; $display("FAIL wrap_status got=%02h required=00", d); end

    // Wrap colliding with a STATUS write: the write wins, no overflow pulse.
    do_reset();
    configure(1, 2'b11, 0, 0);
    build_toggles(255);
    run_wave();
    bus_rd(6'h03, d); checks++;
    if (d !== 8'hFF) begin failures++; $display("FAIL collide_preload got=%02h required=ff", d); end
    timer_in = ~stim[stim.size()-1];
    tick(); tick(); tick(); tick();
    addr = 6'h03; wdata = 8'($urandom); mod_en = 1'b1; wr_en = 1'b1;
    tick();
    wr_en = 1'b0; mod_en = 1'b0;
    checks++;
    if (cnt_en !== 1'b1) begin failures++; $display("FAIL collide_edge_present got=%b required=1", cnt_en); end
    checks++;
    if (edge_ovf !== 1'b0) begin failures++; $display("FAIL collide_ovf got=%b required=0", edge_ovf); end
    tick();
    checks++;
    if (edge_ovf !== 1'b0) begin failures++; $display("FAIL collide_ovf_late got=%b required=0", edge_ovf); end
    bus_rd(6'h03, d); checks++;
    if (d !== 8'h00) begin failures++; $display("FAIL collide_status got=%02h required=00", d); end
    $display("test_wrap done");
  endtask

  task automatic test_disable();
    logic [7:0] d;
    do_reset();
    configure(0, 2'b01, 3, 0);
    stim = {};
    repeat (12) begin
      repeat ($urandom_range(1, 4)) stim.push_back(1'b1);
      repeat ($urandom_range(1, 4)) stim.push_back(1'b0);
    end
    repeat (24) stim.push_back(1'b0);
    run_wave();
    for (int k = 0; k < obs_filt.size(); k++) begin
      checks++;
      if ({obs_filt[k], obs_cnt[k], obs_ovf[k]} !== {exp_filt[k], exp_cnt[k], exp_ovf[k]}) begin
        failures++;
        $display("FAIL disable cycle=%0d got=%b required=%b", k,
                 {obs_filt[k], obs_cnt[k], obs_ovf[k]}, {exp_filt[k], exp_cnt[k], exp_ovf[k]});
      end
    end
    bus_rd(6'h03, d); checks++;
    if (d !== 8'h00) begin failures++; $display("FAIL disable_status got=%02h required=00", d); end
    // Re-enable while the input sits high: no spurious edge.
    timer_in = 1'b1;
    repeat (5) tick();
    bus_wr(6'h00, 8'h05);
    for (int i = 0; i < 12; i++) begin
      tick();
      checks++;
      if ({filt_out, cnt_en} !== 2'b10) begin
        failures++;
        $display("FAIL reenable_quiet cycle=%0d got=%b required=10", i, {filt_out, cnt_en});
      end
    end
    // The filter is live again: a fresh rise gives cnt_en after 2+3+1+1+1 edges.
    timer_in = 1'b0;
    repeat (10) tick();
    timer_in = 1'b1;
    for (int i = 1; i <= 9; i++) begin
      tick();
      checks++;
      if (cnt_en !== (i == 8)) begin
        failures++;
        $display("FAIL reenable_rise tick=%0d got=%b required=%b", i, cnt_en, (i == 8));
      end
    end
    $display("test_disable done");
  endtask

  task automatic test_mid_reset();
    logic [7:0] d;
    do_reset();
    configure(1, 2'b01, 0, 0);
    timer_in = 1'b1;
    tick(); tick(); tick(); tick();   // strobe is now pending
    rst = 1'b1;
    tick();
    checks++;
    if ({filt_out, cnt_en, edge_ovf} !== 3'b000) begin
      failures++;
      $display("FAIL mid_reset_outputs got=%b required=000", {filt_out, cnt_en, edge_ovf});
    end
    bus_rd(6'h00, d); checks++;
    if (d !== 8'h00) begin failures++; $display("FAIL mid_reset_ctrl got=%02h required=00", d); end
    rst = 1'b0;
    tick();
    checks++;
    if (cnt_en !== 1'b0) begin failures++; $display("FAIL mid_reset_cnt_en got=%b required=0", cnt_en); end
    bus_rd(6'h03, d); checks++;
    if (d !== 8'h00) begin failures++; $display("FAIL mid_reset_status got=%02h required=00", d); end
    $display("test_mid_reset done");
  endtask

  initial begin
    test_reset();
    test_registers();
    test_clean_edges();
    test_glitch();
    test_prescale_both();
    test_wrap();
    test_disable();
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule
